// File: rtl/sw_debouncer.sv
// Debounces N_SW board switches: two-flop synchronizer, then one counter per bit that has to
// reach STABLE_CYCLES before the level is accepted. Also produces rise/fall pulses and sticky rise flags.
module sw_debouncer #(
    parameter int N_SW          = 10,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_SW-1:0] ev_clr,
    output logic [N_SW-1:0] SW,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] sw_event,
    output logic            sw_changed
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [N_SW-1:0]  sync1_r;
    logic [N_SW-1:0]  sync2_r;
    logic [N_SW-1:0]  sw_r;
    logic [N_SW-1:0]  rise_r;
    logic [N_SW-1:0]  fall_r;
    logic [N_SW-1:0]  event_r;
    logic             changed_r;
    logic [CNT_W-1:0] cnt_r      [N_SW];

    state_t           state_s    [N_SW];
    logic [CNT_W-1:0] cnt_next_s [N_SW];
    logic [N_SW-1:0]  sw_next_s;
    logic [N_SW-1:0]  rise_next_s;
    logic [N_SW-1:0]  fall_next_s;
    logic [N_SW-1:0]  event_next_s;

    // Per-bit state decode plus next-count / next-level logic.
    // The state is set by whether the synchronized input disagrees with the accepted level.
    always_comb begin
        sw_next_s = sw_r;
        for (int i = 0; i < N_SW; i++) begin
            cnt_next_s[i] = CNT_ZERO;
            if (sync2_r[i] != sw_r[i]) begin
                state_s[i] = ST_COUNT;
            end else begin
                state_s[i] = ST_IDLE;
            end
            case (state_s[i])
                ST_IDLE: begin
                    cnt_next_s[i] = CNT_ZERO;
                end
                ST_COUNT: begin
                    // The terminal compare keeps the counter from wrapping.
                    if (cnt_r[i] == CNT_TERM) begin
                        sw_next_s[i]  = sync2_r[i];
                        cnt_next_s[i] = CNT_ZERO;
                    end else begin
                        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_next_s[i] = CNT_ZERO;
                end
            endcase
        end
        rise_next_s  = sw_next_s & ~sw_r;
        fall_next_s  = ~sw_next_s & sw_r;
        // If a set and a clear fall in the same cycle, the set wins.
        event_next_s = rise_r | (event_r & ~ev_clr);
    end

    // Synchronizer, debounce state, edge pulses and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r   <= '0;
            sync2_r   <= '0;
            sw_r      <= '0;
            rise_r    <= '0;
            fall_r    <= '0;
            event_r   <= '0;
            changed_r <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r   <= sw_raw;
            sync2_r   <= sync1_r;
            sw_r      <= sw_next_s;
            rise_r    <= rise_next_s;
            fall_r    <= fall_next_s;
            event_r   <= event_next_s;
            changed_r <= |(rise_next_s | fall_next_s);
            for (int i = 0; i < N_SW; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    assign SW         = sw_r;
    assign sw_rise    = rise_r;
    assign sw_fall    = fall_r;
    assign sw_event   = event_r;
    assign sw_changed = changed_r;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with STABLE_CYCLES=4. Inputs are driven and outputs are sampled
// on the falling clock edge.
module tb_sw_debouncer;

    logic       clk;
    logic       reset;
    logic [9:0] sw_raw;
    logic [9:0] ev_clr;
    logic [9:0] SW;
    logic [9:0] sw_rise;
    logic [9:0] sw_fall;
    logic [9:0] sw_event;
    logic       sw_changed;

    int n_pass  = 0;
    int n_total = 0;

    sw_debouncer #(
        .N_SW          (10),
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .ev_clr     (ev_clr),
        .SW         (SW),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_event   (sw_event),
        .sw_changed (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = 10'h000;
        ev_clr = 10'h000;
        repeat (3) step();
        chk("rst_sw",      SW,         10'h000);
        chk("rst_rise",    sw_rise,    10'h000);
        chk("rst_fall",    sw_fall,    10'h000);
        chk("rst_event",   sw_event,   10'h000);
        chk("rst_changed", sw_changed, 10'h000);
        reset = 1'b0;

        // Clean rise on bit 0: accepted after the 6th edge.
        sw_raw = 10'h001;
        repeat (5) step();
        chk("clean_early", SW, 10'h000);
        step();
        chk("clean_sw",      SW,         10'h001);
        chk("clean_rise",    sw_rise,    10'h001);
        chk("clean_changed", sw_changed, 10'h001);
        // Clear strobe in the same cycle as the rise pulse: the set wins.
        ev_clr = 10'h001;
        step();
        ev_clr = 10'h000;
        chk("coll_event",   sw_event,   10'h001);
        chk("rise_one_cyc", sw_rise,    10'h000);
        chk("chg_one_cyc",  sw_changed, 10'h000);
        step();
        chk("event_sticky", sw_event, 10'h001);
        ev_clr = 10'h001;
        step();
        ev_clr = 10'h000;
        chk("event_clr", sw_event, 10'h000);

        // Three-clock glitch on bit 9 is rejected.
        sw_raw = 10'h201;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) sw_raw = 10'h001;
            step();
            chk("glitch_sw",   SW,      10'h001);
            chk("glitch_rise", sw_rise, 10'h000);
            chk("glitch_fall", sw_fall, 10'h000);
        end

        // Bit 3 bounces 1,0,1,0 every two clocks, then holds 1.
        for (int t = 0; t < 4; t++) begin
            sw_raw = (t % 2 == 0) ? 10'h009 : 10'h001;
            repeat (2) begin
                step();
                chk("bounce_sw",   SW,      10'h001);
                chk("bounce_rise", sw_rise, 10'h000);
            end
        end
        sw_raw = 10'h009;
        repeat (5) step();
        chk("bounce_early", SW, 10'h001);
        step();
        chk("bounce_sw_acc", SW,      10'h009);
        chk("bounce_rise3",  sw_rise, 10'h008);
        step();
        chk("bounce_event", sw_event, 10'h008);

        // All bits high, then all fall together.
        sw_raw = 10'h3FF;
        repeat (6) step();
        chk("all_sw",   SW,      10'h3FF);
        chk("all_rise", sw_rise, 10'h3F6);
        step();
        chk("all_event", sw_event, 10'h3FE);
        sw_raw = 10'h000;
        repeat (5) step();
        chk("fall_early", SW, 10'h3FF);
        step();
        chk("fall_sw",      SW,         10'h000);
        chk("fall_pulse",   sw_fall,    10'h3FF);
        chk("fall_norise",  sw_rise,    10'h000);
        chk("fall_changed", sw_changed, 10'h001);
        chk("fall_event",   sw_event,   10'h3FE);
        step();
        chk("fall_end",     sw_fall,    10'h000);
        chk("fall_chg_end", sw_changed, 10'h000);
        chk("fall_event2",  sw_event,   10'h3FE);

        // Reset in the middle of a count on bit 5.
        sw_raw = 10'h020;
        repeat (4) step();
        chk("mid_counting", SW, 10'h000);
        reset = 1'b1;
        step();
        chk("mid_rst_sw",      SW,         10'h000);
        chk("mid_rst_rise",    sw_rise,    10'h000);
        chk("mid_rst_fall",    sw_fall,    10'h000);
        chk("mid_rst_event",   sw_event,   10'h000);
        chk("mid_rst_changed", sw_changed, 10'h000);
        reset = 1'b0;
        repeat (5) step();
        chk("mid_early", SW, 10'h000);
        step();
        chk("mid_sw",      SW,         10'h020);
        chk("mid_rise",    sw_rise,    10'h020);
        chk("mid_changed", sw_changed, 10'h001);
        step();
        chk("mid_rise_end", sw_rise,  10'h000);
        chk("mid_event",    sw_event, 10'h020);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
